// File: rtl/mem_port_arbiter.sv
// Two-requester (instruction fetch / data) arbiter for a single memory port.
// Optional feature: define MEM_ARB_RR_EN for round-robin priority (default is fixed D>I).
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_read,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_resp,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_mbe,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_resp,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_mbe,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_resp
);

  localparam int MBE_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t state, state_next;
  logic   last_gnt_d, last_gnt_d_next;
  logic   i_req, d_req, pick_d;

  logic              read_q, write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MBE_W-1:0]  mbe_q;

  // Winner selection among requests sampled in IDLE.
  always_comb begin
    i_req  = i_read;
    d_req  = d_read | d_write;
`ifdef MEM_ARB_RR_EN
    pick_d = d_req && (!i_req || !last_gnt_d);
`else
    pick_d = d_req;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_gnt_d <= 1'b0;
    end else begin
      state      <= state_next;
      last_gnt_d <= last_gnt_d_next;
    end
  end

  always_comb begin
    state_next      = state;
    last_gnt_d_next = last_gnt_d;
    case (state)
      IDLE: begin
        if (pick_d)     state_next = GNT_D;
        else if (i_req) state_next = GNT_I;
      end
      GNT_I: begin
        if (mem_resp) begin
          state_next      = IDLE;
          last_gnt_d_next = 1'b0;
        end
      end
      GNT_D: begin
        if (mem_resp) begin
          state_next      = IDLE;
          last_gnt_d_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The memory port is driven only from these registers so it stays stable
  // for the whole grant regardless of what the requesters do meanwhile.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mbe_q   <= '0;
    end else if (state == IDLE) begin
      if (state_next == GNT_D) begin
        read_q  <= ~d_write;
        write_q <= d_write;
        addr_q  <= d_addr;
        wdata_q <= d_wdata;
        mbe_q   <= d_mbe;
      end else if (state_next == GNT_I) begin
        read_q  <= 1'b1;
        write_q <= 1'b0;
        addr_q  <= i_addr;
        wdata_q <= '0;
        mbe_q   <= '1;
      end
    end else if (mem_resp) begin
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end
  end

  assign mem_read  = read_q;
  assign mem_write = write_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_mbe   = mbe_q;

  assign i_resp  = mem_resp && (state == GNT_I);
  assign d_resp  = mem_resp && (state == GNT_D);
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  // Simultaneous read and write from D is illegal; it is served as a write.
  assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Build with +define+MEM_ARB_RR_EN to check the round-robin variant.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_read;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_resp;
  logic        d_read, d_write;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_mbe;
  logic [31:0] d_rdata;
  logic        d_resp;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_mbe;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_mbe(d_mbe), .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_mbe(mem_mbe), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_read = 0; i_addr = 0; d_read = 0; d_write = 0;
    d_addr = 0; d_wdata = 0; d_mbe = 0; mem_rdata = 0; mem_resp = 0;
    tick(); tick();
    checks++;
    if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_strobes: got %b expected 0000", {mem_read, mem_write, i_resp, d_resp});
    end
    checks++;
    if ({mem_addr, mem_wdata, mem_mbe} !== 68'h0) begin
      failures++;
      $display("[TB] FAIL reset_fields: got %h expected 0", {mem_addr, mem_wdata, mem_mbe});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_lone_fetch();
    int pulses = 0;
    i_read = 1'b1; i_addr = 32'h60;
    tick();
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) begin mem_resp = 1'b1; mem_rdata = 32'h0050_0093; end
      #1;
      checks++;
      if ({mem_read, mem_write, mem_addr, mem_mbe} !== {1'b1, 1'b0, 32'h60, 4'hF}) begin
        failures++;
        $display("[TB] FAIL fetch_port cyc%0d: got rd=%b wr=%b addr=%h mbe=%h expected rd=1 wr=0 addr=60 mbe=f",
                 k, mem_read, mem_write, mem_addr, mem_mbe);
      end
      checks++;
      if ({i_resp, d_resp} !== {k == 4, 1'b0}) begin
        failures++;
        $display("[TB] FAIL fetch_resp cyc%0d: got i=%b d=%b expected i=%b d=0", k, i_resp, d_resp, k == 4);
      end
      if (i_resp === 1'b1) pulses++;
      tick();
    end
    checks++;
    if (i_rdata !== 32'h0050_0093 && pulses != 1) begin
      failures++;
      $display("[TB] FAIL fetch_pulses: got %0d expected 1", pulses);
    end
    i_read = 1'b0; mem_resp = 1'b0; mem_rdata = 32'h0;
    #1;
    checks++;
    if ({mem_read, i_resp} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL fetch_release: got rd=%b i_resp=%b expected 0 0", mem_read, i_resp);
    end
  endtask

  task automatic test_fetch_rdata();
    i_read = 1'b1; i_addr = 32'h70;
    tick();
    mem_resp = 1'b1; mem_rdata = 32'h1234_5678;
    #1;
    checks++;
    if ({i_resp, i_rdata} !== {1'b1, 32'h1234_5678}) begin
      failures++;
      $display("[TB] FAIL fetch_rdata: got resp=%b data=%h expected resp=1 data=12345678", i_resp, i_rdata);
    end
    tick();
    i_read = 1'b0; mem_resp = 1'b0;
    tick();
  endtask

  task automatic test_store();
    d_write = 1'b1; d_addr = 32'h104; d_wdata = 32'hAABB_CCDD; d_mbe = 4'b1100;
    tick();
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) mem_resp = 1'b1;
      #1;
      checks++;
      if ({mem_read, mem_write, mem_addr, mem_wdata, mem_mbe} !== {1'b0, 1'b1, 32'h104, 32'hAABB_CCDD, 4'b1100}) begin
        failures++;
        $display("[TB] FAIL store_port cyc%0d: got rd=%b wr=%b addr=%h wdata=%h mbe=%b expected 0 1 104 aabbccdd 1100",
                 k, mem_read, mem_write, mem_addr, mem_wdata, mem_mbe);
      end
      checks++;
      if ({d_resp, i_resp} !== {k == 3, 1'b0}) begin
        failures++;
        $display("[TB] FAIL store_resp cyc%0d: got d=%b i=%b expected d=%b i=0", k, d_resp, i_resp, k == 3);
      end
      tick();
    end
    d_write = 1'b0; mem_resp = 1'b0;
    #1;
    checks++;
    if ({mem_write, d_resp} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL store_release: got wr=%b d_resp=%b expected 0 0", mem_write, d_resp);
    end
  endtask

  // last grant before this task is D (the store)
  task automatic test_contention();
    logic [31:0] first_addr, second_addr;
`ifdef MEM_ARB_RR_EN
    first_addr = 32'h64; second_addr = 32'h200;
`else
    first_addr = 32'h200; second_addr = 32'h64;
`endif
    i_read = 1'b1; i_addr = 32'h64; d_read = 1'b1; d_addr = 32'h200;
    tick();
    checks++;
    if ({mem_read, mem_addr} !== {1'b1, first_addr}) begin
      failures++;
      $display("[TB] FAIL contention_first: got rd=%b addr=%h expected rd=1 addr=%h", mem_read, mem_addr, first_addr);
    end
    mem_resp = 1'b1; mem_rdata = 32'hCAFE_0001;
    #1;
    checks++;
    if ({i_resp, d_resp} !== {first_addr == 32'h64, first_addr == 32'h200}) begin
      failures++;
      $display("[TB] FAIL contention_resp1: got i=%b d=%b", i_resp, d_resp);
    end
    tick();
    mem_resp = 1'b0;
    if (first_addr == 32'h64) i_read = 1'b0; else d_read = 1'b0;
    #1;
    checks++;
    if (mem_read !== 1'b0) begin
      failures++;
      $display("[TB] FAIL contention_idle_gap: got rd=%b expected 0", mem_read);
    end
    tick();
    checks++;
    if ({mem_read, mem_addr} !== {1'b1, second_addr}) begin
      failures++;
      $display("[TB] FAIL contention_second: got rd=%b addr=%h expected rd=1 addr=%h", mem_read, mem_addr, second_addr);
    end
    mem_resp = 1'b1;
    #1;
    checks++;
    if ({i_resp, d_resp} !== {second_addr == 32'h64, second_addr == 32'h200}) begin
      failures++;
      $display("[TB] FAIL contention_resp2: got i=%b d=%b", i_resp, d_resp);
    end
    tick();
    mem_resp = 1'b0; i_read = 1'b0; d_read = 1'b0;
    tick();
  endtask

  // last grant is now I in fixed mode, D in round-robin mode
  task automatic test_contention_again();
    logic [31:0] expect_addr;
`ifdef MEM_ARB_RR_EN
    expect_addr = 32'h84;
`else
    expect_addr = 32'h280;
`endif
    i_read = 1'b1; i_addr = 32'h84; d_read = 1'b1; d_addr = 32'h280;
    tick();
    checks++;
    if (mem_addr !== expect_addr) begin
      failures++;
      $display("[TB] FAIL contention_again: got addr=%h expected %h", mem_addr, expect_addr);
    end
    rst = 1'b1; i_read = 1'b0; d_read = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_stability();
    d_read = 1'b1; d_addr = 32'h200;
    tick();
    d_addr = 32'h300;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({mem_read, mem_addr} !== {1'b1, 32'h200}) begin
        failures++;
        $display("[TB] FAIL stability cyc%0d: got rd=%b addr=%h expected rd=1 addr=200", k, mem_read, mem_addr);
      end
      tick();
    end
    d_read = 1'b0;
    mem_resp = 1'b1; mem_rdata = 32'h0BAD_F00D;
    #1;
    checks++;
    if ({d_resp, d_rdata} !== {1'b1, 32'h0BAD_F00D}) begin
      failures++;
      $display("[TB] FAIL stability_resp: got resp=%b data=%h expected resp=1 data=0badf00d", d_resp, d_rdata);
    end
    tick();
    mem_resp = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    d_read = 1'b1; d_addr = 32'h400;
    tick();
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0; d_addr = 32'h404;
    #1;
    checks++;
    if (mem_read !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_gap: got rd=%b expected 0", mem_read);
    end
    tick();
    checks++;
    if ({mem_read, mem_addr} !== {1'b1, 32'h404}) begin
      failures++;
      $display("[TB] FAIL b2b_second: got rd=%b addr=%h expected rd=1 addr=404", mem_read, mem_addr);
    end
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0; d_read = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_grant();
    d_read = 1'b1; d_addr = 32'h500;
    tick();
    checks++;
    if (mem_read !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rst_grant_setup: got rd=%b expected 1", mem_read);
    end
    rst = 1'b1; d_read = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({mem_read, mem_write, d_resp} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL rst_grant: got rd=%b wr=%b d_resp=%b expected 000", mem_read, mem_write, d_resp);
    end
    mem_resp = 1'b1;
    #1;
    checks++;
    if ({i_resp, d_resp} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL stray_resp: got i=%b d=%b expected 00", i_resp, d_resp);
    end
    tick();
    mem_resp = 1'b0;
    #1;
    checks++;
    if ({mem_read, mem_write} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL stray_resp_state: got rd=%b wr=%b expected 00", mem_read, mem_write);
    end
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_fetch_rdata();
    test_store();
    test_contention();
    test_contention_again();
    test_stability();
    test_back_to_back();
    test_reset_mid_grant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
